// File: rtl/imem_pkg.sv
// imem_pkg: shared widths, phase enum and starvation default for the instruction-memory arbiter
package imem_pkg;
   localparam int ADDR_W = 8;
   localparam int DATA_W = 32;
   localparam int STARVE_MAX_DEF = 4;
   typedef enum logic {BOOT, RUN} imem_state_e;
endpackage

// File: rtl/imem_if.sv
// imem_if: fetch, loader and memory-side signals of the instruction-memory arbiter
interface imem_if import imem_pkg::*;;
   logic              fetch_req;
   logic [ADDR_W-1:0] fetch_addr;
   logic              fetch_gnt;
   logic              fetch_rvalid;
   logic [DATA_W-1:0] fetch_rdata;
   logic              load_req;
   logic [ADDR_W-1:0] load_addr;
   logic [DATA_W-1:0] load_wdata;
   logic              load_done;
   logic              load_gnt;
   logic              load_err;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              boot_done;
   modport master (
      output fetch_req, fetch_addr, load_req, load_addr, load_wdata, load_done, mem_rdata,
      input  fetch_gnt, fetch_rvalid, fetch_rdata, load_gnt, load_err, mem_addr, mem_we, mem_wdata, boot_done
   );
   modport slave (
      input  fetch_req, fetch_addr, load_req, load_addr, load_wdata, load_done, mem_rdata,
      output fetch_gnt, fetch_rvalid, fetch_rdata, load_gnt, load_err, mem_addr, mem_we, mem_wdata, boot_done
   );
endinterface

// File: rtl/imem_starve_ctr.sv
// imem_starve_ctr: saturating count of consecutive denied loader cycles, raising force_gnt at the limit
module imem_starve_ctr import imem_pkg::*; #(
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic req,
   input  logic gnt,
   output logic force_gnt
);
   logic [3:0] cnt;
   // count denials while enabled; any grant, idle loader or disable restarts the count
   always_ff @(posedge clk) begin
      if (!rst_n || !en || !req || gnt) cnt <= '0;
      else if (cnt != 4'(STARVE_MAX)) cnt <= cnt + 4'd1;
   end
   assign force_gnt = cnt == 4'(STARVE_MAX);
endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: BOOT/RUN arbiter sharing the instruction memory between fetch and loader; IMEM_WRITE_PROTECT_EN rejects RUN writes
module imem_arbiter import imem_pkg::*; #(
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input logic clk,
   input logic rst_n,
   imem_if.slave bus
);
   imem_state_e state, state_nxt;
   logic run, force_gnt, starve_en;
   // phase register, back to BOOT on reset
   always_ff @(posedge clk) begin
      state <= !rst_n ? BOOT : state_nxt;
   end
   // the loader's completion pulse only matters while booting
   always_comb begin
      state_nxt = (state == BOOT && bus.load_done) ? RUN : state;
   end
   // grants: loader owns BOOT, fetch has priority in RUN unless the loader is starving
   always_comb begin
      run = state == RUN;
      bus.boot_done = run;
      bus.fetch_gnt = run && bus.fetch_req && !force_gnt;
`ifdef IMEM_WRITE_PROTECT_EN
      bus.load_gnt = !run && bus.load_req;
`else
      bus.load_gnt = bus.load_req && (!run || !bus.fetch_req || force_gnt);
`endif
   end
`ifdef IMEM_WRITE_PROTECT_EN
   assign starve_en = 1'b0;
   // one error pulse per rejected RUN write cycle
   always_ff @(posedge clk) begin
      bus.load_err <= rst_n && run && bus.load_req;
   end
`else
   assign starve_en = run;
   assign bus.load_err = 1'b0;
`endif
   imem_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
      .clk(clk), .rst_n(rst_n), .en(starve_en), .req(bus.load_req), .gnt(bus.load_gnt), .force_gnt(force_gnt)
   );
   // memory port follows whichever side holds the grant, idle drives zeros
   always_comb begin
      bus.mem_we = bus.load_gnt;
      bus.mem_addr = bus.load_gnt ? bus.load_addr : bus.fetch_gnt ? bus.fetch_addr : '0;
      bus.mem_wdata = bus.load_gnt ? bus.load_wdata : '0;
   end
   // capture read data one cycle after the fetch grant
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.fetch_rvalid <= 1'b0;
         bus.fetch_rdata <= '0;
      end else begin
         bus.fetch_rvalid <= bus.fetch_gnt;
         if (bus.fetch_gnt) bus.fetch_rdata <= bus.mem_rdata;
      end
   end
endmodule
